// File: rtl/lib_sync_pkg.sv
// Shared limits, defaults and helpers for the synchroniser / pulse-stretch library.
package lib_sync_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int STRETCH_LEN_DEF = 3;
  localparam int STRETCH_LEN_MIN = 1;
  localparam int STRETCH_LEN_MAX = 255;
  localparam int RETRIGGER_DEF   = 1;

  // What a synchronised rising edge does to the stretch counter.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_LOAD   = 2'd1,
    EV_RETRIG = 2'd2,
    EV_IGNORE = 2'd3
  } stretch_ev_e;

  function automatic int cnt_width(input int len);
    return $clog2(len + 32'sd1);
  endfunction

  function automatic stretch_ev_e stretch_event(input logic rise, input logic hit,
                                                input logic retrig);
    stretch_ev_e ev;
    if (!rise) begin
      ev = EV_NONE;
    end else if (!hit) begin
      ev = EV_LOAD;
    end else if (retrig) begin
      ev = EV_RETRIG;
    end else begin
      ev = EV_IGNORE;
    end
    return ev;
  endfunction

  function automatic logic params_in_range(input int num_ch, input int sync_stages,
                                           input int stretch_len, input int retrigger);
    return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
           (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
           (stretch_len >= STRETCH_LEN_MIN) && (stretch_len <= STRETCH_LEN_MAX) &&
           ((retrigger == 32'sd0) || (retrigger == 32'sd1));
  endfunction

endpackage

// File: rtl/multi_sync_stretch_chk.sv
// Invariant checker bound into multi_sync_stretch; pure observation, no outputs.
module multi_sync_stretch_chk
  import lib_sync_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STRETCH_LEN = STRETCH_LEN_DEF,
  parameter int RETRIGGER   = RETRIGGER_DEF
) (
  input logic              clk,
  input logic              rst_n,
  input logic [NUM_CH-1:0] rise,
  input logic [NUM_CH-1:0] fall,
  input logic [NUM_CH-1:0] stretch,
  input logic              busy
);

  localparam logic PARAMS_OK = params_in_range(NUM_CH, SYNC_STAGES, STRETCH_LEN, RETRIGGER);
  localparam logic [NUM_CH-1:0] NONE = {NUM_CH{1'b0}};

  a_params:      assert property (@(posedge clk) PARAMS_OK);
  a_busy:        assert property (@(posedge clk) disable iff (!rst_n) busy == (|stretch));
  a_edge_excl:   assert property (@(posedge clk) disable iff (!rst_n) (rise & fall) == NONE);
  a_rise_single: assert property (@(posedge clk) disable iff (!rst_n) (rise & $past(rise)) == NONE);
  // A rise always starts or extends a stretch in the same cycle.
  a_rise_str:    assert property (@(posedge clk) disable iff (!rst_n) (rise & ~stretch) == NONE);

endmodule

// File: rtl/sync_chain.sv
// Single-bit flop chain that brings an asynchronous level into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_r;

  generate
    if (STAGES == 1) begin : g_one
      // Degenerate single-flop chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_r <= 1'b0;
        end else begin
          sync_r <= d;
        end
      end
    end else begin : g_multi
      // Shift the input toward the MSB; the MSB is the synchronised level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_r <= {STAGES{1'b0}};
        end else begin
          sync_r <= {sync_r[STAGES-2:0], d};
        end
      end
    end
  endgenerate

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/multi_sync_stretch.sv
// Per-channel CDC synchroniser with registered edge pulses, pulse stretcher and
// sticky overflow flag for rises that land on an active stretch.
module multi_sync_stretch
  import lib_sync_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STRETCH_LEN = STRETCH_LEN_DEF,
  parameter int RETRIGGER   = RETRIGGER_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_signal,
  input  logic [NUM_CH-1:0] i_clr_ovf,
  output logic [NUM_CH-1:0] o_sync,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_stretch,
  output logic [NUM_CH-1:0] o_ovf,
  output logic              o_busy
);

  localparam int              CNT_W     = cnt_width(STRETCH_LEN);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_LEN);
  localparam logic            RETRIG_EN = (RETRIGGER != 32'sd0);

  logic [NUM_CH-1:0] sync_s;
  logic [NUM_CH-1:0] stretch_nxt_s;
  logic              busy_r;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic             prev_r;
      logic             rise_r;
      logic             fall_r;
      logic             stretch_r;
      logic             ovf_r;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt_s;
      logic             rise_det_s;
      logic             fall_det_s;
      logic             ovf_hit_s;
      stretch_ev_e      ev_s;

      sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (sys_clk),
        .rst_n(rst_n),
        .d    (i_signal[g]),
        .q    (sync_s[g])
      );

      assign rise_det_s = sync_s[g] & ~prev_r;
      assign fall_det_s = ~sync_s[g] & prev_r;
      // A count of 1 is the last stretch cycle, so a rise there chains seamlessly.
      assign ev_s       = stretch_event(rise_det_s, (cnt_r > CNT_ONE), RETRIG_EN);

      // Next stretch count and overflow hit for this channel.
      always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_hit_s = 1'b0;
        case (ev_s)
          EV_LOAD: begin
            cnt_nxt_s = CNT_LOAD;
          end
          EV_RETRIG: begin
            cnt_nxt_s = CNT_LOAD;
            ovf_hit_s = 1'b1;
          end
          EV_IGNORE: begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            ovf_hit_s = 1'b1;
          end
          EV_NONE: begin
            if (cnt_r != CNT_ZERO) begin
              cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
              cnt_nxt_s = CNT_ZERO;
            end
          end
          default: begin
            cnt_nxt_s = CNT_ZERO;
            ovf_hit_s = 1'b0;
          end
        endcase
      end

      // Channel state; o_stretch tracks the count being loaded so it rises with o_rise.
      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_r    <= 1'b0;
          rise_r    <= 1'b0;
          fall_r    <= 1'b0;
          cnt_r     <= CNT_ZERO;
          stretch_r <= 1'b0;
          ovf_r     <= 1'b0;
        end else begin
          prev_r    <= sync_s[g];
          rise_r    <= rise_det_s;
          fall_r    <= fall_det_s;
          cnt_r     <= cnt_nxt_s;
          stretch_r <= (cnt_nxt_s != CNT_ZERO);
          ovf_r     <= ovf_hit_s | (ovf_r & ~i_clr_ovf[g]);
        end
      end

      assign stretch_nxt_s[g] = (cnt_nxt_s != CNT_ZERO);
      assign o_rise[g]        = rise_r;
      assign o_fall[g]        = fall_r;
      assign o_stretch[g]     = stretch_r;
      assign o_ovf[g]         = ovf_r;
    end
  endgenerate

  // Busy is built from the next-state stretch bits so it lines up with o_stretch.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= |stretch_nxt_s;
    end
  end

  assign o_sync = sync_s;
  assign o_busy = busy_r;

  multi_sync_stretch_chk #(
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .STRETCH_LEN(STRETCH_LEN),
    .RETRIGGER  (RETRIGGER)
  ) u_chk (
    .clk    (sys_clk),
    .rst_n  (rst_n),
    .rise   (o_rise),
    .fall   (o_fall),
    .stretch(o_stretch),
    .busy   (o_busy)
  );

endmodule

// File: tb/tb_multi_sync_stretch.sv
// Bench for multi_sync_stretch: three parameterisations driven together, checked
// by a history-based reference model feeding a scoreboard queue plus directed checks.
module tb_multi_sync_stretch;

  typedef struct {
    int         inst;
    logic [7:0] sync;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] stretch;
    logic [7:0] ovf;
    logic       busy;
  } exp_t;

  logic       sys_clk;
  logic       rst_n;
  logic [3:0] sig0, clr0, sig1, clr1;
  logic [7:0] sig2, clr2;
  logic [3:0] sync0, rise0, fall0, str0, ovf0;
  logic [3:0] sync1, rise1, fall1, str1, ovf1;
  logic [7:0] sync2, rise2, fall2, str2, ovf2;
  logic       busy0, busy1, busy2;

  exp_t       sbq[$];
  logic [7:0] hist [3][5];
  int         rem  [3][8];
  logic [7:0] movf [3];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rise_model_cnt = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  multi_sync_stretch u0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .i_signal(sig0), .i_clr_ovf(clr0),
    .o_sync(sync0), .o_rise(rise0), .o_fall(fall0), .o_stretch(str0),
    .o_ovf(ovf0), .o_busy(busy0));

  multi_sync_stretch #(.RETRIGGER(0)) u1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .i_signal(sig1), .i_clr_ovf(clr1),
    .o_sync(sync1), .o_rise(rise1), .o_fall(fall1), .o_stretch(str1),
    .o_ovf(ovf1), .o_busy(busy1));

  multi_sync_stretch #(.NUM_CH(8), .SYNC_STAGES(3), .STRETCH_LEN(5)) u2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .i_signal(sig2), .i_clr_ovf(clr2),
    .o_sync(sync2), .o_rise(rise2), .o_fall(fall2), .o_stretch(str2),
    .o_ovf(ovf2), .o_busy(busy2));

  function automatic int p_nch(input int m); return (m == 2) ? 8 : 4; endfunction
  function automatic int p_s(input int m);   return (m == 2) ? 3 : 2; endfunction
  function automatic int p_len(input int m); return (m == 2) ? 5 : 3; endfunction
  function automatic int p_ret(input int m); return (m == 1) ? 0 : 1; endfunction

  // Reference model: o_sync is the input seen S edges ago, edges come from the
  // two previous synchronised samples, the stretch is a remaining-cycles count.
  task automatic model_push(input int m, input logic [7:0] sig, input logic [7:0] clr);
    exp_t e;
    logic [7:0] osync, oprev, rd, fd, strv, mask;
    e.inst = m;
    if (rst_n !== 1'b1) begin
      for (int k = 0; k < 5; k++) hist[m][k] = 8'h00;
      for (int c = 0; c < 8; c++) rem[m][c] = 0;
      movf[m] = 8'h00;
      e.sync = 8'h00; e.rise = 8'h00; e.fall = 8'h00;
      e.stretch = 8'h00; e.ovf = 8'h00; e.busy = 1'b0;
    end else begin
      osync = hist[m][p_s(m)-1];
      oprev = hist[m][p_s(m)];
      rd = osync & ~oprev;
      fd = ~osync & oprev;
      mask = 8'h00;
      strv = 8'h00;
      for (int c = 0; c < p_nch(m); c++) begin
        mask[c] = 1'b1;
        if (rd[c] && rem[m][c] > 1) begin
          movf[m][c] = 1'b1;
          rem[m][c] = (p_ret(m) == 1) ? p_len(m) : rem[m][c] - 1;
        end else begin
          if (clr[c]) movf[m][c] = 1'b0;
          if (rd[c]) rem[m][c] = p_len(m);
          else if (rem[m][c] > 0) rem[m][c] = rem[m][c] - 1;
        end
        strv[c] = (rem[m][c] != 0);
      end
      for (int k = 4; k > 0; k--) hist[m][k] = hist[m][k-1];
      hist[m][0] = sig & mask;
      e.sync = hist[m][p_s(m)-1];
      e.rise = rd; e.fall = fd; e.stretch = strv; e.ovf = movf[m]; e.busy = |strv;
      if (m == 2) rise_model_cnt += $countones(rd);
    end
    sbq.push_back(e);
  endtask

  // One clock: record expectations for the coming edge, then return 1 ns after it.
  task automatic step();
    @(negedge sys_clk);
    #1;
    model_push(0, {4'h0, sig0}, {4'h0, clr0});
    model_push(1, {4'h0, sig1}, {4'h0, clr1});
    model_push(2, sig2, clr2);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle(input int n);
    sig0 = 4'h0; sig1 = 4'h0; sig2 = 8'h00;
    clr0 = 4'h0; clr1 = 4'h0; clr2 = 8'h00;
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard: compare each expectation once its edge has passed.
  always @(negedge sys_clk) begin
    exp_t e;
    logic [7:0] os, ori, of, ost, oo;
    logic ob;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.inst)
        0: begin os = {4'h0, sync0}; ori = {4'h0, rise0}; of = {4'h0, fall0};
                 ost = {4'h0, str0}; oo = {4'h0, ovf0}; ob = busy0; end
        1: begin os = {4'h0, sync1}; ori = {4'h0, rise1}; of = {4'h0, fall1};
                 ost = {4'h0, str1}; oo = {4'h0, ovf1}; ob = busy1; end
        default: begin os = sync2; ori = rise2; of = fall2;
                 ost = str2; oo = ovf2; ob = busy2; end
      endcase
      n_checks += 6;
      if (os !== e.sync) begin n_errors++;
        $display("FAIL sb_u%0d_sync got %h expected %h t=%0t", e.inst, os, e.sync, $time); end
      if (ori !== e.rise) begin n_errors++;
        $display("FAIL sb_u%0d_rise got %h expected %h t=%0t", e.inst, ori, e.rise, $time); end
      if (of !== e.fall) begin n_errors++;
        $display("FAIL sb_u%0d_fall got %h expected %h t=%0t", e.inst, of, e.fall, $time); end
      if (ost !== e.stretch) begin n_errors++;
        $display("FAIL sb_u%0d_stretch got %h expected %h t=%0t", e.inst, ost, e.stretch, $time); end
      if (oo !== e.ovf) begin n_errors++;
        $display("FAIL sb_u%0d_ovf got %h expected %h t=%0t", e.inst, oo, e.ovf, $time); end
      if (ob !== e.busy) begin n_errors++;
        $display("FAIL sb_u%0d_busy got %b expected %b t=%0t", e.inst, ob, e.busy, $time); end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    settle(2);
    n_checks++;
    if ({sync0, rise0, fall0, str0, ovf0, busy0} !== 21'd0) begin n_errors++;
      $display("FAIL reset_u0 got %h expected 0", {sync0, rise0, fall0, str0, ovf0, busy0}); end
    n_checks++;
    if ({sync2, rise2, fall2, str2, ovf2, busy2} !== 41'd0) begin n_errors++;
      $display("FAIL reset_u2 got %h expected 0", {sync2, rise2, fall2, str2, ovf2, busy2}); end
    rst_n = 1'b1;
    settle(4);
  endtask

  task automatic test_single_rise();
    int first_sync, first_rise, rise_cnt;
    logic [15:0] str_mask, busy_mask;
    first_sync = -1; first_rise = -1; rise_cnt = 0;
    str_mask = 16'h0000; busy_mask = 16'h0000;
    sig0 = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (sync0[0] && first_sync < 0) first_sync = k;
      if (rise0[0]) begin rise_cnt++; if (first_rise < 0) first_rise = k; end
      str_mask[k] = str0[0];
      busy_mask[k] = busy0;
    end
    n_checks += 5;
    if (first_sync != 2) begin n_errors++; $display("FAIL single_sync_edge got %0d expected 2", first_sync); end
    if (first_rise != 3) begin n_errors++; $display("FAIL single_rise_edge got %0d expected 3", first_rise); end
    if (rise_cnt != 1) begin n_errors++; $display("FAIL single_rise_count got %0d expected 1", rise_cnt); end
    if (str_mask !== 16'h0038) begin n_errors++; $display("FAIL single_stretch_edges got %h expected 0038", str_mask); end
    if (busy_mask !== 16'h0038) begin n_errors++; $display("FAIL single_busy_edges got %h expected 0038", busy_mask); end
    settle(6);
  endtask

  // Rises on ch1 two edges apart (0->1, 1->0, 0->1 on consecutive samples): the
  // second lands while the count is 2, so u0 reloads (edges 3..7) and u1 does not (3..5).
  task automatic test_retrigger();
    logic [15:0] m0, m1;
    m0 = 16'h0000; m1 = 16'h0000;
    for (int k = 1; k <= 10; k++) begin
      sig0[1] = (k != 2);
      sig1[1] = (k != 2);
      step();
      m0[k] = str0[1];
      m1[k] = str1[1];
    end
    n_checks += 4;
    if (m0 !== 16'h00F8) begin n_errors++; $display("FAIL retrig1_stretch got %h expected 00f8", m0); end
    if (m1 !== 16'h0038) begin n_errors++; $display("FAIL retrig0_stretch got %h expected 0038", m1); end
    if (ovf0[1] !== 1'b1) begin n_errors++; $display("FAIL retrig1_ovf got %b expected 1", ovf0[1]); end
    if (ovf1[1] !== 1'b1) begin n_errors++; $display("FAIL retrig0_ovf got %b expected 1", ovf1[1]); end
    clr0[1] = 1'b1;
    clr1[1] = 1'b1;
    step();
    clr0[1] = 1'b0;
    clr1[1] = 1'b0;
    n_checks += 2;
    if (ovf1[1] !== 1'b0) begin n_errors++; $display("FAIL retrig0_ovf_clr got %b expected 0", ovf1[1]); end
    if (ovf0[1] !== 1'b0) begin n_errors++; $display("FAIL retrig1_ovf_clr got %b expected 0", ovf0[1]); end
    settle(6);
  endtask

  task automatic test_ovf_clr_collision();
    for (int k = 1; k <= 7; k++) begin
      sig0[2] = (k != 2);
      sig1[2] = (k != 2);
      clr0[2] = (k == 5);
      clr1[2] = (k == 5);
      step();
      if (k == 5 || k == 7) begin
        n_checks += 2;
        if (ovf0[2] !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins_u0 k=%0d got %b expected 1", k, ovf0[2]); end
        if (ovf1[2] !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins_u1 k=%0d got %b expected 1", k, ovf1[2]); end
      end
    end
    clr0 = 4'hF; clr1 = 4'hF;
    step();
    settle(6);
  endtask

  task automatic test_reset_mid_stretch();
    sig0 = 4'h1;
    for (int k = 1; k <= 4; k++) step();
    n_checks++;
    if (str0[0] !== 1'b1) begin n_errors++; $display("FAIL midreset_pre_stretch got %b expected 1", str0[0]); end
    rst_n = 1'b0;
    sbq.delete();
    #1;
    n_checks += 3;
    if ({sync0, rise0, fall0, str0, ovf0, busy0} !== 21'd0) begin n_errors++;
      $display("FAIL midreset_u0 got %h expected 0", {sync0, rise0, fall0, str0, ovf0, busy0}); end
    if ({sync1, rise1, fall1, str1, ovf1, busy1} !== 21'd0) begin n_errors++;
      $display("FAIL midreset_u1 got %h expected 0", {sync1, rise1, fall1, str1, ovf1, busy1}); end
    if ({sync2, rise2, fall2, str2, ovf2, busy2} !== 41'd0) begin n_errors++;
      $display("FAIL midreset_u2 got %h expected 0", {sync2, rise2, fall2, str2, ovf2, busy2}); end
    sig0 = 4'hF;
    sig1 = 4'hF;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (rise0 !== ((k == 3) ? 4'hF : 4'h0)) begin n_errors++;
        $display("FAIL release_rise k=%0d got %h expected %h", k, rise0, (k == 3) ? 4'hF : 4'h0); end
    end
    settle(8);
  endtask

  task automatic test_random();
    int hold [3][8];
    logic [7:0] v [3];
    int obs_rise;
    for (int m = 0; m < 3; m++) begin
      v[m] = 8'h00;
      for (int c = 0; c < 8; c++) hold[m][c] = 0;
    end
    obs_rise = 0;
    rise_model_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 3; m++) begin
        for (int c = 0; c < p_nch(m); c++) begin
          if (hold[m][c] == 0) begin
            v[m][c] = ~v[m][c];
            hold[m][c] = $urandom_range(1, 4);
          end
          hold[m][c] = hold[m][c] - 1;
        end
      end
      sig0 = v[0][3:0];
      sig1 = v[1][3:0];
      sig2 = v[2];
      for (int c = 0; c < 8; c++) begin
        clr2[c] = ($urandom_range(0, 7) == 0);
        if (c < 4) begin
          clr0[c] = ($urandom_range(0, 7) == 0);
          clr1[c] = ($urandom_range(0, 7) == 0);
        end
      end
      step();
      obs_rise += $countones(rise2);
    end
    n_checks++;
    if (obs_rise != rise_model_cnt) begin n_errors++;
      $display("FAIL random_rise_total got %0d expected %0d", obs_rise, rise_model_cnt); end
    settle(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    sig0 = 4'h0; sig1 = 4'h0; sig2 = 8'h00;
    clr0 = 4'h0; clr1 = 4'h0; clr2 = 8'h00;
    test_reset();
    test_single_rise();
    test_retrigger();
    test_ovf_clr_collision();
    test_reset_mid_stretch();
    test_random();
    @(negedge sys_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
